sync_pixel_fetch: RTL and testbench

SYNC_PIXEL_FETCH -- requirements
Module: sync_pixel_fetch

---
 rtl/video_pkg.sv | 36 +++
 rtl/sync_pixel_fetch_pipe_delay.sv | 25 ++
 rtl/sync_pixel_fetch.sv | 130 +++++++++++++
 tb/tb_sync_pixel_fetch.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video types, 720p timing defaults and colour-bar lookup for the pixel fetch path.
// The optional colour-bar generator is enabled by defining TEST_PATTERN_EN.
package video_pkg;

    typedef logic [23:0] pixel_t;
    typedef logic [19:0] addr_t;

    localparam int DEF_H_ACT  = 1280;
    localparam int DEF_H_FP   = 110;
    localparam int DEF_H_SYNC = 40;
    localparam int DEF_V_ACT  = 720;
    localparam int DEF_V_FP   = 5;
    localparam int DEF_V_SYNC = 5;
    localparam int DEF_H_POL  = 1;
    localparam int DEF_V_POL  = 1;
    localparam int DEF_RD_LAT = 2;

    localparam int BAR_COUNT = 8;

    // Bars run left to right in the classic descending-luma order.
    function automatic pixel_t bar_color(input logic [2:0] bar);
        pixel_t c;
        case (bar)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sync_pixel_fetch_pipe_delay.sv
// Fixed-depth shift register used to keep timing flags aligned with framebuffer read data.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/sync_pixel_fetch.sv
// Turns upstream raster counts into framebuffer reads and aligned hsync/vsync/de/rgb outputs.
// Define TEST_PATTERN_EN to add the test_mode input and the colour-bar generator.
module sync_pixel_fetch
    import video_pkg::*;
#(
    parameter int H_ACT  = DEF_H_ACT,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int V_ACT  = DEF_V_ACT,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int H_POL  = DEF_H_POL,
    parameter int V_POL  = DEF_V_POL,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] horz_count,
    input  logic [31:0] vert_count,
`ifdef TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    output logic        rd_en,
    output addr_t       rd_addr,
    input  pixel_t      rd_data,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output pixel_t      rgb,
    output logic        frame_start
);

    localparam logic [31:0] H_ACT_U   = 32'(H_ACT);
    localparam logic [31:0] V_ACT_U   = 32'(V_ACT);
    localparam logic [31:0] HS_START  = 32'(H_ACT + H_FP);
    localparam logic [31:0] HS_END    = 32'(H_ACT + H_FP + H_SYNC);
    localparam logic [31:0] VS_START  = 32'(V_ACT + V_FP);
    localparam logic [31:0] VS_END    = 32'(V_ACT + V_FP + V_SYNC);
    localparam logic        H_ON      = (H_POL != 0);
    localparam logic        V_ON      = (V_POL != 0);

    logic active, sync_h, sync_v, origin, fetch, read_req, armed;

    assign active = (horz_count < H_ACT_U) && (vert_count < V_ACT_U);
    assign sync_h = (horz_count >= HS_START) && (horz_count < HS_END);
    assign sync_v = (vert_count >= VS_START) && (vert_count < VS_END);
    assign origin = (horz_count == 32'd0) && (vert_count == 32'd0);
    // Nothing is fetched or displayed until a frame origin has been seen since reset.
    assign fetch  = active && (armed || origin);

`ifdef TEST_PATTERN_EN
    localparam int PW = 4 + 1 + 32;
    assign read_req = fetch && !test_mode;
`else
    localparam int PW = 4;
    assign read_req = fetch;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            armed   <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
        end else begin
            if (origin) armed <= 1'b1;
            rd_en <= read_req;
            if (origin)     rd_addr <= '0;
            else if (rd_en) rd_addr <= rd_addr + 20'd1;
        end
    end

    logic [PW-1:0] pipe_in, pipe_out;

`ifdef TEST_PATTERN_EN
    assign pipe_in = {fetch, sync_h, sync_v, origin && active, test_mode, horz_count};
`else
    assign pipe_in = {fetch, sync_h, sync_v, origin && active};
`endif

    pipe_delay #(.WIDTH(PW), .DEPTH(RD_LAT + 1)) u_align (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (pipe_in),
        .dout    (pipe_out)
    );

    logic   act_d, sh_d, sv_d, fs_d;
    pixel_t pixel_next;

    assign act_d = pipe_out[PW-1];
    assign sh_d  = pipe_out[PW-2];
    assign sv_d  = pipe_out[PW-3];
    assign fs_d  = pipe_out[PW-4];

`ifdef TEST_PATTERN_EN
    localparam int BAR_W = (H_ACT / BAR_COUNT > 0) ? H_ACT / BAR_COUNT : 1;
    logic        tm_d;
    logic [31:0] bar_idx;
    pixel_t      pattern;

    assign tm_d    = pipe_out[32];
    assign bar_idx = pipe_out[31:0] / 32'(BAR_W);
    assign pattern = bar_color((bar_idx > 32'd7) ? 3'd7 : bar_idx[2:0]);
`endif

    always_comb begin
        pixel_next = '0;
        if (act_d) pixel_next = rd_data;
`ifdef TEST_PATTERN_EN
        if (act_d && tm_d) pixel_next = pattern;
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hsync       <= ~H_ON;
            vsync       <= ~V_ON;
            de          <= 1'b0;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= sh_d ? H_ON : ~H_ON;
            vsync       <= sv_d ? V_ON : ~V_ON;
            de          <= act_d;
            rgb         <= pixel_next;
            frame_start <= fs_d;
        end
    end

endmodule

// File: tb/tb_sync_pixel_fetch.sv
// Directed bench for sync_pixel_fetch: default 720p instance plus a tiny-raster instance for address wrap.
module tb_sync_pixel_fetch;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] horz, vert;

    logic        rd_en, hsync, vsync, de, frame_start;
    logic [19:0] rd_addr;
    logic [23:0] rd_data, rgb;

    logic        rd_en2, hsync2, vsync2, de2, frame_start2;
    logic [19:0] rd_addr2;
    logic [23:0] rd_data2, rgb2;

`ifdef TEST_PATTERN_EN
    logic test_mode = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    sync_pixel_fetch dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .horz_count  (horz),
        .vert_count  (vert),
`ifdef TEST_PATTERN_EN
        .test_mode   (test_mode),
`endif
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .rgb         (rgb),
        .frame_start (frame_start)
    );

    sync_pixel_fetch #(
        .H_ACT(16), .H_FP(2), .H_SYNC(3), .V_ACT(4), .V_FP(1), .V_SYNC(1)
    ) dut_small (
        .clock       (clock),
        .reset_n     (reset_n),
        .horz_count  (horz),
        .vert_count  (vert),
`ifdef TEST_PATTERN_EN
        .test_mode   (test_mode),
`endif
        .rd_en       (rd_en2),
        .rd_addr     (rd_addr2),
        .rd_data     (rd_data2),
        .hsync       (hsync2),
        .vsync       (vsync2),
        .de          (de2),
        .rgb         (rgb2),
        .frame_start (frame_start2)
    );

    // Framebuffer model: two-cycle read latency, data = 0xA in the top nibble over the address.
    logic [20:0] fb_p1 = '0, fb_p2 = '0, fb2_p1 = '0, fb2_p2 = '0;
    always @(posedge clock) begin
        fb_p1  <= {rd_en, rd_addr};
        fb_p2  <= fb_p1;
        fb2_p1 <= {rd_en2, rd_addr2};
        fb2_p2 <= fb2_p1;
    end
    assign rd_data  = fb_p2[20]  ? {4'hA, fb_p2[19:0]}  : 24'h5A5A5A;
    assign rd_data2 = fb2_p2[20] ? {4'hA, fb2_p2[19:0]} : 24'h5A5A5A;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int h, input int v);
        horz = 32'(h);
        vert = 32'(v);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int hs_ones;
        int vs_lines;
        int reads;
        logic exp_b;

        reset_n = 1'b0;
        horz = 32'd2000;
        vert = 32'd800;
        repeat (3) @(posedge clock);
        #1;
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_de", 32'(de), 32'd0);
        check("rst_rgb", 32'(rgb), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_hsync", 32'(hsync), 32'd0);
        check("rst_vsync", 32'(vsync), 32'd0);
        reset_n = 1'b1;

        // Active counts before any origin must not fetch.
        tick(5, 5);
        tick(6, 5);
        check("pre_origin_rd_en", 32'(rd_en), 32'd0);
        tick(0, 0);
        check("origin_rd_en", 32'(rd_en), 32'd1);
        check("origin_rd_addr", 32'(rd_addr), 32'd0);
        check("pre_origin_de", 32'(de), 32'd0);
        tick(1, 0);
        check("addr_1", 32'(rd_addr), 32'd1);
        tick(2, 0);
        tick(3, 0);
        check("fs_de", 32'(de), 32'd1);
        check("fs_pulse", 32'(frame_start), 32'd1);
        check("fs_rgb", 32'(rgb), 32'hA00000);
        tick(4, 0);
        check("fs_pulse_end", 32'(frame_start), 32'd0);
        check("rgb_px1", 32'(rgb), 32'hA00001);

        // Horizontal sync: output reflects the count three ticks back.
        hs_ones = 0;
        for (int h = 1380; h <= 1440; h++) begin
            tick(h, 0);
            exp_b = (h - 3 >= 1390) && (h - 3 < 1430);
            check("hsync_window", 32'(hsync), 32'(exp_b));
            hs_ones += int'(hsync);
        end
        check("hsync_width", 32'(hs_ones), 32'd40);

        // Vertical sync: hold each line long enough to drain the pipeline.
        vs_lines = 0;
        for (int v = 720; v <= 731; v++) begin
            for (int h = 1300; h <= 1304; h++) tick(h, v);
            exp_b = (v >= 725) && (v < 730);
            check("vsync_line", 32'(vsync), 32'(exp_b));
            check("vblank_de", 32'(de), 32'd0);
            vs_lines += int'(vsync);
        end
        check("vsync_lines", 32'(vs_lines), 32'd5);

        // Full frame on the small raster: 16x4 active, 21x6 total.
        reads = 0;
        for (int v = 0; v < 6; v++) begin
            for (int h = 0; h < 21; h++) begin
                tick(h, v);
                exp_b = (h < 16) && (v < 4);
                check("small_rd_en", 32'(rd_en2), 32'(exp_b));
                reads += int'(rd_en2);
                if (h == 15 && v == 3) check("small_last_addr", 32'(rd_addr2), 32'd63);
                if (h == 18 && v == 3) begin
                    check("small_last_rgb", 32'(rgb2), 32'hA0003F);
                    check("small_last_de", 32'(de2), 32'd1);
                end
                if (h == 19 && v == 3) check("small_de_off", 32'(de2), 32'd0);
            end
        end
        check("small_reads", 32'(reads), 32'd64);
        tick(0, 0);
        check("small_wrap_addr", 32'(rd_addr2), 32'd0);
        check("small_wrap_rd_en", 32'(rd_en2), 32'd1);

        // Mid-frame reset at (500,300).
        for (int h = 496; h <= 500; h++) tick(h, 300);
        check("mid_de", 32'(de), 32'd1);
        check("mid_rd_en", 32'(rd_en), 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_rd_en", 32'(rd_en), 32'd0);
        check("arst_rd_addr", 32'(rd_addr), 32'd0);
        check("arst_de", 32'(de), 32'd0);
        check("arst_rgb", 32'(rgb), 32'd0);
        check("arst_hsync", 32'(hsync), 32'd0);
        tick(500, 300);
        tick(500, 300);
        reset_n = 1'b1;
        for (int h = 501; h <= 505; h++) tick(h, 300);
        check("post_rst_rd_en", 32'(rd_en), 32'd0);
        check("post_rst_de", 32'(de), 32'd0);
        tick(0, 0);
        check("resume_rd_en", 32'(rd_en), 32'd1);
        check("resume_rd_addr", 32'(rd_addr), 32'd0);
        tick(1, 0);
        tick(2, 0);
        tick(3, 0);
        check("resume_fs", 32'(frame_start), 32'd1);
        check("resume_rgb", 32'(rgb), 32'hA00000);

`ifdef TEST_PATTERN_EN
        test_mode = 1'b1;
        tick(160, 0);
        check("tp_rd_en", 32'(rd_en), 32'd0);
        tick(161, 0);
        tick(162, 0);
        tick(163, 0);
        check("tp_yellow", 32'(rgb), 32'hFFFF00);
        tick(1279, 0);
        check("tp_rd_en_end", 32'(rd_en), 32'd0);
        tick(1280, 0);
        tick(1281, 0);
        tick(1282, 0);
        check("tp_black_de", 32'(de), 32'd1);
        check("tp_black", 32'(rgb), 32'h000000);
        test_mode = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
